// File: rtl/aes_pkg.sv
// Shared AES helpers for the cipher datapath.
// Contents:
//   COL_W / NUM_COLS - column width in bits and columns per 128-bit state
//   mixState_t       - control states of the iterative MixColumns unit
//   xtime / gf_mul3  - GF(2^8) multiply-by-2 and multiply-by-3, polynomial 0x11B
package aes_pkg;

    localparam int COL_W    = 32;
    localparam int NUM_COLS = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } mixState_t;

    // Multiply by x in GF(2^8): shift left, fold the carried-out bit back via 0x1B.
    function automatic logic [7:0] xtime(input logic [7:0] x);
        return {x[6:0], 1'b0} ^ (x[7] ? 8'h1B : 8'h00);
    endfunction

    // Multiply by (x + 1) in GF(2^8).
    function automatic logic [7:0] gf_mul3(input logic [7:0] x);
        return xtime(x) ^ x;
    endfunction

endpackage

// File: rtl/mix_columns_iter_col.sv
// Combinational MixColumns of one 32-bit column.
// Ports:
//   colIn  - input column, row 0 in bits 31:24
//   colOut - mixed column, same byte layout
module mix_single_column
    import aes_pkg::*;
(
    input  logic [COL_W-1:0] colIn,
    output logic [COL_W-1:0] colOut
);

    logic [7:0] r0_s, r1_s, r2_s, r3_s;

    assign r0_s = colIn[31:24];
    assign r1_s = colIn[23:16];
    assign r2_s = colIn[15:8];
    assign r3_s = colIn[7:0];

    // Circulant matrix rows {2,3,1,1} rotated once per output byte.
    assign colOut[31:24] = xtime(r0_s) ^ gf_mul3(r1_s) ^ r2_s ^ r3_s;
    assign colOut[23:16] = r0_s ^ xtime(r1_s) ^ gf_mul3(r2_s) ^ r3_s;
    assign colOut[15:8]  = r0_s ^ r1_s ^ xtime(r2_s) ^ gf_mul3(r3_s);
    assign colOut[7:0]   = gf_mul3(r0_s) ^ r1_s ^ r2_s ^ xtime(r3_s);

endmodule

// File: rtl/mix_columns_iter.sv
// Iterative AES MixColumns: accepts one 128-bit state on an input handshake,
// mixes COLS_PER_CYCLE columns per clock, and presents the result on an
// output handshake. A new state is accepted only after the result is taken.
// Ports:
//   clk      - clock, rising edge
//   reset    - asynchronous active-high reset
//   inValid  - stateIn valid
//   inReady  - unit idle and able to accept
//   stateIn  - input state, column c = stateIn[127-32c -: 32]
//   outValid - stateOut holds a finished result
//   outReady - downstream takes the result
//   stateOut - mixed state, same layout as stateIn
module mix_columns_iter
    import aes_pkg::*;
#(
    parameter int COLS_PER_CYCLE = 1
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         inValid,
    output logic         inReady,
    input  logic [127:0] stateIn,
    output logic         outValid,
    input  logic         outReady,
    output logic [127:0] stateOut
);

    if ((COLS_PER_CYCLE != 1) && (COLS_PER_CYCLE != 2) && (COLS_PER_CYCLE != 4)) begin : gBadCols
        $error("mix_columns_iter: COLS_PER_CYCLE must be 1, 2 or 4");
    end

    // colIdx value at which the current step writes the final column(s).
    localparam logic [2:0] LAST_IDX = 3'(NUM_COLS - COLS_PER_CYCLE);
    localparam logic [1:0] IDX_STEP = 2'(COLS_PER_CYCLE);

    mixState_t        state_r, nextState_s;
    logic [1:0]       colIdx_r;
    logic [COL_W-1:0] workCol_r   [NUM_COLS];
    logic [COL_W-1:0] resultCol_r [NUM_COLS];
    logic [COL_W-1:0] mixIn_s     [COLS_PER_CYCLE];
    logic [COL_W-1:0] mixOut_s    [COLS_PER_CYCLE];
    logic             inReady_r, outValid_r;
    logic             lastStep_s;

    assign lastStep_s = ({1'b0, colIdx_r} == LAST_IDX);

    for (genvar i = 0; i < COLS_PER_CYCLE; i++) begin : gLane
        // Lane i handles column colIdx+i; colIdx is a multiple of
        // COLS_PER_CYCLE, so the sum never wraps.
        assign mixIn_s[i] = workCol_r[colIdx_r + 2'(i)];
        mix_single_column uMix (
            .colIn  (mixIn_s[i]),
            .colOut (mixOut_s[i])
        );
    end

    // Next-state decode for the IDLE -> BUSY -> DONE control sequence.
    always_comb begin
        nextState_s = state_r;
        case (state_r)
            IDLE: begin
                if (inValid) begin
                    nextState_s = BUSY;
                end else begin
                    nextState_s = IDLE;
                end
            end
            BUSY: begin
                if (lastStep_s) begin
                    nextState_s = DONE;
                end else begin
                    nextState_s = BUSY;
                end
            end
            DONE: begin
                if (outReady) begin
                    nextState_s = IDLE;
                end else begin
                    nextState_s = DONE;
                end
            end
            default: nextState_s = IDLE;
        endcase
    end

    // State, handshake flags, column counter, work and result registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r    <= IDLE;
            colIdx_r   <= 2'd0;
            inReady_r  <= 1'b1;
            outValid_r <= 1'b0;
            for (int c = 0; c < NUM_COLS; c++) begin
                workCol_r[c]   <= 32'h0;
                resultCol_r[c] <= 32'h0;
            end
        end else begin
            state_r    <= nextState_s;
            // Handshake flags are decoded from the next state so they are
            // plain flops aligned with state_r.
            inReady_r  <= (nextState_s == IDLE);
            outValid_r <= (nextState_s == DONE);
            case (state_r)
                IDLE: begin
                    if (inValid) begin
                        colIdx_r <= 2'd0;
                        for (int c = 0; c < NUM_COLS; c++) begin
                            workCol_r[c] <= stateIn[127 - COL_W*c -: COL_W];
                        end
                    end else begin
                        colIdx_r <= colIdx_r;
                    end
                end
                BUSY: begin
                    colIdx_r <= colIdx_r + IDX_STEP;
                    for (int i = 0; i < COLS_PER_CYCLE; i++) begin
                        resultCol_r[colIdx_r + 2'(i)] <= mixOut_s[i];
                    end
                end
                default: begin
                    colIdx_r <= colIdx_r;
                end
            endcase
        end
    end

    assign inReady  = inReady_r;
    assign outValid = outValid_r;
    assign stateOut = {resultCol_r[0], resultCol_r[1], resultCol_r[2], resultCol_r[3]};

endmodule

// File: doc/mix_columns_iter.md
Name: mix_columns_iter

Overview:
- Iterative AES MixColumns unit for the encryption datapath; the forward counterpart of the inverse-mix stage used in decryption.
- Takes one 128-bit state through a valid/ready handshake and transforms COLS_PER_CYCLE columns per clock.
- Returns the mixed state through a second valid/ready handshake.
- Sits between ShiftRows and AddRoundKey in the sequential cipher round.

Parameters:
- COLS_PER_CYCLE, 1: columns mixed per clock; legal values 1, 2, 4. Any other value is an elaboration error.

Ports:
- clk  input  1  the only clock; all state updates on its rising edge
- reset  input  1  asynchronous, active-high reset
- inValid  input  1  stateIn is valid
- inReady  output  1  block can accept a state
- stateIn  input  128  input state; column c = stateIn[127-32c -: 32], row 0 in the top byte of each column
- outValid  output  1  stateOut holds a finished result
- outReady  input  1  downstream accepts the result
- stateOut  output  128  mixed state, same byte layout as stateIn

Behaviour:
- Arithmetic: GF(2^8) with reduction polynomial 0x11B.
  - xtime(x) = (x<<1) ^ (x[7] ? 0x1B : 0).
  - Per column, r0..r3 -> s0..s3:
    - s0 = 2r0^3r1^r2^r3
    - s1 = r0^2r1^3r2^r3
    - s2 = r0^r1^2r2^3r3
    - s3 = 3r0^r1^r2^2r3
  - 3x = xtime(x)^x. Everything is 8-bit wide with no carries.
- FSM states: IDLE, BUSY, DONE.
- IDLE:
  - inReady=1, outValid=0.
  - On inValid&inReady: latch stateIn into the work register, colIdx=0, go to BUSY.
- BUSY:
  - inReady=0, outValid=0.
  - Each cycle, columns colIdx..colIdx+COLS_PER_CYCLE-1 are mixed and written into the result register. Column 0 is bits 127:96.
  - colIdx advances by COLS_PER_CYCLE.
  - When the last column is written, go to DONE.
- DONE:
  - outValid=1, stateOut=result, inReady=0.
  - Hold stateOut and outValid stable until outReady=1, then go to IDLE.
  - No back-to-back accept in the same cycle as the output handshake: inReady rises the cycle after the output handshake.
- Latency: outValid rises exactly 4/COLS_PER_CYCLE cycles after the accepting edge (4, 2, 1). Throughput is one state per (latency+2) cycles.
- inValid while not ready: ignored. stateIn must not be sampled outside IDLE.
- outReady while outValid=0: no effect.
- Reset:
  - Asynchronous, effective immediately, including mid-BUSY or in DONE with a pending result.
  - FSM=IDLE, colIdx=0, work/result registers=0, stateOut=0, outValid=0.
  - inReady=1 in the first cycle after reset deassertion.
  - Any in-flight state is discarded.
- Output registering: stateOut comes only from the result register. Partially written results are never visible, because outValid is 0 until DONE.

Decomposition:
- Shared package aes_pkg:
  - xtime function and gf_mul3 helper.
  - FSM state encoding (IDLE/BUSY/DONE).
  - Column width constant (32) and column count (4).
- Sub-module mix_single_column: combinational, 32-bit in / 32-bit out. COLS_PER_CYCLE instances are generated and muxed by colIdx.

Test Plan:
- Single column (FIPS-197 worked example), input 0xdb135345 in column 0 with the other columns zero -> column 0 = 0x8e4da1bc. Separately, 0xf20a225c -> 0x9fdc589d; 0xc6c6c6c6 and 0x01010101 map to themselves.
- Full-state round-trip against the decryption stage:
  - stateIn=4773b91ff72f354361cb018ea1e6cf2c -> stateOut=bd6e7c3df2b5779e0b61216e8b10b689.
  - stateIn=2d7e86a339d9393ee6570a1101904e16 -> fde3bad205e5d0d73547964ef1fe37f1.
  - Both must hold for COLS_PER_CYCLE = 1, 2 and 4, with outValid at cycle 4, 2 and 1 after the accept respectively.
- FIPS-197 round 1, stateIn=d4bf5d30e0b452aeb84111f11e2798e5 -> 046681e5e0cb199a48f8d37a2806264c.
- Backpressure:
  - Hold outReady=0 for 10 cycles after outValid: stateOut and outValid stay stable and inReady=0.
  - A new inValid during this window is not accepted.
  - Release outReady: outValid falls, and inReady=1 on the next cycle.
- Reset mid-operation:
  - Assert reset asynchronously (between clock edges) during BUSY colIdx=2: outputs clear immediately, with stateOut=0, outValid=0, inReady=1.
  - The next accepted state 39daee38f4f1a82aaf432410c36d45b9 gives d1876c0f79c4300ab45594add66ff41f with no residue from the aborted state.
- Streaming: 20 random states with random inValid/outReady gaps, checked against a reference model; outputs arrive in order, none dropped or duplicated.
